mul_seq_n: RTL



---
 rtl/mul_seq_n.sv | 111 +++++++++++
 1 files changed

// File: rtl/mul_seq_n.sv
// Sequential shift-add multiplier: one adder, WIDTH iterations per product,
// unsigned or two's-complement operands selected per operation.
module mul_seq_n #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] y
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    y_q, y_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    count_q, count_d;
  logic             neg_q, neg_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]    acc_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      acc_q       <= '0;
      y_q         <= '0;
      mplier_q    <= '0;
      count_q     <= '0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
      y_q         <= y_d;
      mplier_q    <= mplier_d;
      count_q     <= count_d;
      neg_q       <= neg_d;
      out_valid_q <= out_valid_d;
    end
  end

  // The most negative operand negates to 2^(WIDTH-1), which still fits as an unsigned magnitude.
  always_comb begin
    a_mag   = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    b_mag   = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
    acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    acc_d       = acc_q;
    y_d         = y_q;
    mplier_d    = mplier_q;
    count_d     = count_q;
    neg_d       = neg_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          neg_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          count_d  = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        // Shifting the multiplicand each step is equivalent to adding it shifted by the count.
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 1'b1;
        if (count_q == CW'(WIDTH - 1)) begin
          y_d         = neg_q ? (~acc_sum + 1'b1) : acc_sum;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign y         = y_q;

endmodule
